serial_byte_receiver: RTL and testbench
=======================================

Name: serial_byte_receiver

Overview:
Serial-in, parallel-out receiver. It is the receiving end of the byte-serial link driven by the 8-bit shift register (parallel load, shift right/left).
- Assembles WIDTH serial bits into a word, shifting LSB-first or MSB-first.
- Presents the word with a valid/ack handshake and flags overrun when the consumer is too slow.
- Sits between the serial link and the CPU data path / register file write port.

Parameters:
WIDTH, 8, word width in bits; must be >= 2.
CNT_W, $clog2(WIDTH), bit-counter width; derived, do not override.

Ports:
CLK  input  1  clock, all state updates on posedge.
RST  input  1  asynchronous active-high reset.
Start  input  1  begin a new frame; also clears Overrun.
Stop  input  1  abort reception and return to IDLE.
Dir  input  1  bit order, sampled at Start: 0 = LSB-first (shift right), 1 = MSB-first (shift left).
Sin  input  1  serial data bit.
Sin_en  input  1  Sin is valid this cycle.
Ack  input  1  consumer has taken Data_out.
Data_out  output  WIDTH  last completed word.
Data_valid  output  1  Data_out holds an unacknowledged word.
Busy  output  1  high in RECV.
Overrun  output  1  sticky: a completed word was dropped.
Bit_cnt  output  CNT_W  bits received in the current word.

Behaviour:
- Reset (async, any state, any cycle, including mid-frame):
  - state = IDLE.
  - Shift register, Data_out, Bit_cnt = 0.
  - Data_valid, Busy, Overrun = 0.
  - dir_r = 0.
- States:
  - IDLE: Sin/Sin_en ignored. Start -> RECV; clears shift reg and Bit_cnt, latches dir_r <= Dir, clears Overrun.
  - RECV: Busy = 1, loops word after word until Stop.
- Priority in RECV: Stop > Start > Sin_en.
  - Stop -> IDLE next cycle; partial bits discarded, Bit_cnt = 0.
  - Start in RECV restarts the frame: shift reg and Bit_cnt cleared, Dir relatched, Overrun cleared, Sin_en that cycle ignored.
- Shift on Sin_en in RECV:
  - dir_r = 0: sh <= {Sin, sh[WIDTH-1:1]}.
  - dir_r = 1: sh <= {sh[WIDTH-2:0], Sin}.
  - Bit_cnt increments.
  - With Sin_en low, sh and Bit_cnt hold.
- Word completion: Sin_en with Bit_cnt == WIDTH-1.
  - Bit_cnt wraps to 0, state stays RECV.
  - Accepted if Data_valid == 0 or Ack is high the same cycle: Data_out <= next sh value (including the current Sin), Data_valid <= 1.
  - Otherwise: Data_out and Data_valid unchanged, word dropped, Overrun <= 1.
  - Latency: Data_valid high on the first cycle after the clock edge that samples the final bit.
- Handshake:
  - Ack with Data_valid = 1 and no completion -> Data_valid <= 0.
  - Ack with Data_valid = 0 is ignored.
  - Data_out holds until overwritten by an accepted word; Stop and Start do not clear Data_out or Data_valid.
- Overrun clears only on RST or Start.
- All outputs are registered; no combinational input-to-output paths.

Decomposition:
- Shared constants header (the team's CPU defines include): state encodings ST_IDLE = 1'b0, ST_RECV = 1'b1; DIR_LSB_FIRST = 1'b0, DIR_MSB_FIRST = 1'b1.
- Natural sub-module: shift_in_core (WIDTH).
  - Ports: CLK, RST, clr, en, dir, sin, q.
  - Bidirectional shift-in register.
- Top level owns the FSM, counter, handshake and overrun.

Test Plan:
1. LSB-first: Start with Dir = 0, then Sin = 1,0,1,1,0,0,1,0 on 8 consecutive Sin_en cycles -> Data_out = 8'h4D, Data_valid = 1 one cycle after the 8th bit, Bit_cnt = 0, Busy = 1.
2. MSB-first: same Sin sequence with Dir = 1 -> Data_out = 8'hB2. Repeat with random Sin_en gaps -> same result, Bit_cnt holds during gaps.
3. Overrun: Dir = 0, send 0xA5 then 0x3C with no Ack -> Data_out stays 8'hA5, Overrun = 1. Then Ack -> Data_valid = 0, Overrun still 1. Then Start -> Overrun = 0.
4. Coincident Ack: Ack asserted on the final-bit cycle of the second word 0x3C while Data_valid = 1 -> Data_out = 8'h3C, Data_valid stays 1, Overrun = 0.
5. Abort/restart: after 3 bits assert Stop -> IDLE, Busy = 0, Bit_cnt = 0, Data_out unchanged. After 3 bits assert Start and Stop together -> IDLE. Start alone mid-word -> next 8 bits form a clean word.
6. Async reset mid-frame: RST pulsed between clock edges after 5 bits with Data_valid = 1 -> all outputs 0 immediately, before the next CLK edge. Sin_en in IDLE is ignored.

Source files
------------

// File: rtl/serial_byte_receiver_pkg.sv
// Shared constants for the serial byte receiver: FSM state encoding and
// bit-order selectors.
package serial_byte_receiver_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;

  localparam logic DIR_LSB_FIRST = 1'b0;
  localparam logic DIR_MSB_FIRST = 1'b1;

endpackage

// File: rtl/serial_byte_receiver_shift_in_core.sv
// Bidirectional shift-in register. LSB-first data enters at the top and
// moves right; MSB-first data enters at the bottom and moves left.
module shift_in_core
  import serial_byte_receiver_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             en,
  input  logic             dir,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  // Clear has priority over shifting; hold when neither is requested.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      if (dir == DIR_MSB_FIRST) begin
        q <= {q[WIDTH-2:0], sin};
      end else begin
        q <= {sin, q[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/serial_byte_receiver.sv
// Serial-in, parallel-out receiver: assembles WIDTH bits per word, presents
// each completed word on Data_out and flags words dropped by a slow consumer.
//
// Handshake: Data_valid high means Data_out holds a word the consumer has not
// yet taken. Ack while Data_valid is high consumes it. A completing word is
// accepted when Data_valid is low or Ack is high in the same cycle; otherwise
// it is dropped and Overrun is set (sticky until RST or Start).
module serial_byte_receiver
  import serial_byte_receiver_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Dir,
  input  logic             Sin,
  input  logic             Sin_en,
  input  logic             Ack,
  output logic [WIDTH-1:0] Data_out,
  output logic             Data_valid,
  output logic             Busy,
  output logic             Overrun,
  output logic [CNT_W-1:0] Bit_cnt,
  output logic             Dbg_state
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_dir;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [WIDTH-1:0]   r_data;
  logic               r_valid;
  logic               r_overrun;
  logic [WIDTH-1:0]   w_sh;
  logic [WIDTH-1:0]   w_sh_nxt;
  logic               w_recv;
  logic               w_abort;
  logic               w_restart;
  logic               w_clr;
  logic               w_shift;
  logic               w_complete;
  logic               w_accept;

  // Decode this cycle's action with Stop > Start > Sin_en while receiving.
  always_comb begin
    w_recv     = (r_state == ST_RECV);
    w_abort    = w_recv && Stop;
    w_restart  = Start && !w_abort;
    w_clr      = w_abort || w_restart;
    w_shift    = w_recv && Sin_en && !Stop && !Start;
    w_complete = w_shift && (r_bit_cnt == CNT_W'(WIDTH - 1));
    w_accept   = !r_valid || Ack;
    if (r_dir == DIR_MSB_FIRST) begin
      w_sh_nxt = {w_sh[WIDTH-2:0], Sin};
    end else begin
      w_sh_nxt = {Sin, w_sh[WIDTH-1:1]};
    end
  end

  shift_in_core #(.WIDTH(WIDTH)) u_shift (
    .CLK (CLK),
    .RST (RST),
    .clr (w_clr),
    .en  (w_shift),
    .dir (r_dir),
    .sin (Sin),
    .q   (w_sh)
  );

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: Start enters RECV, Stop leaves it, RECV loops word to word.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (Start) w_state_nxt = ST_RECV;
      ST_RECV: if (Stop)  w_state_nxt = ST_IDLE;
      default:            w_state_nxt = ST_IDLE;
    endcase
  end

  // Bit order latch and bit counter; counter wraps on word completion.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_dir     <= DIR_LSB_FIRST;
      r_bit_cnt <= '0;
    end else begin
      if (w_restart) r_dir <= Dir;
      if (w_clr || w_complete) begin
        r_bit_cnt <= '0;
      end else if (w_shift) begin
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
    end
  end

  // Output word, valid flag and sticky overrun.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_complete && w_accept) begin
        r_data  <= w_sh_nxt;
        r_valid <= 1'b1;
      end else if (Ack) begin
        r_valid <= 1'b0;
      end
      if (w_restart) begin
        r_overrun <= 1'b0;
      end else if (w_complete && !w_accept) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign Data_out   = r_data;
  assign Data_valid = r_valid;
  assign Busy       = (r_state == ST_RECV);
  assign Overrun    = r_overrun;
  assign Bit_cnt    = r_bit_cnt;
  assign Dbg_state  = r_state;

endmodule

// File: tb/tb_serial_byte_receiver.sv
module tb_serial_byte_receiver;
  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, stop = 1'b0, dir = 1'b0, sin = 1'b0, sin_en = 1'b0, ack = 1'b0;
  logic [W-1:0] data_out;
  logic data_valid, busy, overrun, dbg_state;
  logic [2:0] bit_cnt;

  always #5 clk = ~clk;

  serial_byte_receiver #(.WIDTH(W)) dut (
    .CLK(clk), .RST(rst), .Start(start), .Stop(stop), .Dir(dir), .Sin(sin),
    .Sin_en(sin_en), .Ack(ack), .Data_out(data_out), .Data_valid(data_valid),
    .Busy(busy), .Overrun(overrun), .Bit_cnt(bit_cnt), .Dbg_state(dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  // Bits of the current word are kept in arrival order; the word value is
  // built only when WIDTH bits have arrived.
  logic         m_busy, m_dir, m_valid, m_ovr;
  logic [W-1:0] m_data;
  logic         m_bits[$];
  logic [W-1:0] exp_q[$];

  task automatic model_reset();
    m_busy = 0; m_dir = 0; m_valid = 0; m_ovr = 0; m_data = '0;
    m_bits.delete();
  endtask

  task automatic model_step();
    logic done;
    logic [W-1:0] w;
    done = 0;
    w = '0;
    if (m_busy && stop) begin
      m_busy = 0; m_bits.delete();
    end else if (start) begin
      m_busy = 1; m_bits.delete(); m_dir = dir; m_ovr = 0;
    end else if (m_busy && sin_en) begin
      m_bits.push_back(sin);
      if (m_bits.size() == W) begin
        for (int k = 0; k < W; k++) begin
          if (m_dir) w[W-1-k] = m_bits[k];
          else       w[k]     = m_bits[k];
        end
        done = 1;
        m_bits.delete();
      end
    end
    if (done) begin
      if (!m_valid || ack) begin m_data = w; m_valid = 1; end
      else m_ovr = 1;
    end else if (ack) begin
      m_valid = 0;
    end
  endtask

  function automatic logic [13:0] model_vec();
    return {m_data, m_valid, m_busy, m_ovr, 3'(m_bits.size())};
  endfunction

  // ---------------- driver tasks ----------------
  // Drive inputs, clock once, advance the model, then sit 1 ns past the edge.
  task automatic step(input logic s_start, s_stop, s_dir, s_sin, s_en, s_ack);
    start = s_start; stop = s_stop; dir = s_dir; sin = s_sin; sin_en = s_en; ack = s_ack;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic send_word(input logic [W-1:0] val, input logic d, input logic ack_last);
    for (int k = 0; k < W; k++)
      step(0, 0, d, d ? val[W-1-k] : val[k], 1, ack_last && (k == W-1));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1;
    model_reset();
    #1;
    n_tests++;
    if ({data_out, data_valid, busy, overrun, bit_cnt, dbg_state} !== 15'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", {data_out, data_valid, busy, overrun, bit_cnt, dbg_state});
    end
    #20;
    rst = 0;
  endtask

  task automatic test_lsb_first();
    logic pat[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) step(0, 0, 0, pat[k], 1, 0);
    n_tests++;
    if ({data_out, data_valid, bit_cnt, busy} !== {8'h4D, 1'b1, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL lsb_word: got data=%h v=%b cnt=%0d busy=%b required 4d 1 0 1", data_out, data_valid, bit_cnt, busy);
    end
    step(0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_msb_first();
    logic pat[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
    step(1, 0, 1, 0, 0, 0);
    for (int k = 0; k < 8; k++) step(0, 0, 1, pat[k], 1, 0);
    n_tests++;
    if ({data_out, data_valid, bit_cnt} !== {8'hB2, 1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL msb_word: got data=%h v=%b cnt=%0d required b2 1 0", data_out, data_valid, bit_cnt);
    end
    step(1, 0, 1, 0, 0, 1);
    for (int k = 0; k < 8; k++) begin
      int gaps = $urandom_range(0, 3);
      for (int g = 0; g < gaps; g++) begin
        step(0, 0, 1, 1'($urandom_range(0, 1)), 0, 0);
        n_tests++;
        if (bit_cnt !== 3'(k)) begin
          n_fail++;
          $display("FAIL msb_gap_hold: got cnt=%0d required %0d", bit_cnt, k);
        end
      end
      step(0, 0, 1, pat[k], 1, 0);
    end
    n_tests++;
    if ({data_out, data_valid, bit_cnt} !== {8'hB2, 1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL msb_gapped_word: got data=%h v=%b cnt=%0d required b2 1 0", data_out, data_valid, bit_cnt);
    end
    step(0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_overrun();
    step(1, 0, 0, 0, 0, 0);
    send_word(8'hA5, 0, 0);
    n_tests++;
    if ({data_out, data_valid, overrun} !== {8'hA5, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL ovr_first: got data=%h v=%b ovr=%b required a5 1 0", data_out, data_valid, overrun);
    end
    send_word(8'h3C, 0, 0);
    n_tests++;
    if ({data_out, data_valid, overrun} !== {8'hA5, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL ovr_drop: got data=%h v=%b ovr=%b required a5 1 1", data_out, data_valid, overrun);
    end
    step(0, 0, 0, 0, 0, 1);
    n_tests++;
    if ({data_valid, overrun} !== 2'b01) begin
      n_fail++;
      $display("FAIL ovr_ack: got v=%b ovr=%b required 0 1", data_valid, overrun);
    end
    step(1, 0, 0, 0, 0, 0);
    n_tests++;
    if ({overrun, busy, data_out} !== {1'b0, 1'b1, 8'hA5}) begin
      n_fail++;
      $display("FAIL ovr_start_clear: got ovr=%b busy=%b data=%h required 0 1 a5", overrun, busy, data_out);
    end
  endtask

  task automatic test_coincident_ack();
    send_word(8'hA5, 0, 0);
    send_word(8'h3C, 0, 1);
    n_tests++;
    if ({data_out, data_valid, overrun} !== {8'h3C, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL coincident_ack: got data=%h v=%b ovr=%b required 3c 1 0", data_out, data_valid, overrun);
    end
    step(0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_abort_restart();
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 1, 0);
    step(0, 1, 0, 0, 0, 0);
    n_tests++;
    if ({busy, bit_cnt, data_out, dbg_state} !== {1'b0, 3'd0, 8'h3C, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_stop: got busy=%b cnt=%0d data=%h st=%b required 0 0 3c 0", busy, bit_cnt, data_out, dbg_state);
    end
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 1, 0);
    step(1, 1, 1, 0, 0, 0);
    n_tests++;
    if ({busy, bit_cnt} !== {1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL abort_start_stop: got busy=%b cnt=%0d required 0 0", busy, bit_cnt);
    end
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 1, 0);
    step(1, 0, 1, 1, 1, 0);
    n_tests++;
    if ({busy, bit_cnt} !== {1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL restart_clear: got busy=%b cnt=%0d required 1 0", busy, bit_cnt);
    end
    send_word(8'h96, 1, 0);
    n_tests++;
    if ({data_out, data_valid} !== {8'h96, 1'b1}) begin
      n_fail++;
      $display("FAIL restart_word: got data=%h v=%b required 96 1", data_out, data_valid);
    end
  endtask

  task automatic test_async_reset();
    // Data_valid is still high from the previous test.
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 1'($urandom_range(0, 1)), 1, 0);
    #2;
    rst = 1;
    model_reset();
    #1;
    n_tests++;
    if ({data_out, data_valid, busy, overrun, bit_cnt} !== 14'h0) begin
      n_fail++;
      $display("FAIL async_reset: got %h required 0", {data_out, data_valid, busy, overrun, bit_cnt});
    end
    #12;
    rst = 0;
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 1, 0);
    n_tests++;
    if ({busy, bit_cnt, data_valid} !== 5'b0) begin
      n_fail++;
      $display("FAIL idle_ignores_sin: got busy=%b cnt=%0d v=%b required 0 0 0", busy, bit_cnt, data_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic d;
    d = 1'($urandom_range(0, 1));
    step(1, 0, d, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] v, e;
      v = W'($urandom);
      exp_q.push_back(v);
      send_word(v, d, 1);
      e = exp_q.pop_front();
      n_tests++;
      if ({data_out, data_valid, overrun} !== {e, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got data=%h v=%b ovr=%b required %h 1 0", i, data_out, data_valid, overrun, e);
      end
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 2, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 12);
      n_tests++;
      if ({data_out, data_valid, busy, overrun, bit_cnt} !== model_vec() || dbg_state !== m_busy) begin
        n_fail++;
        if (bad < 10)
          $display("FAIL random[%0d]: got %h st=%b required %h st=%b", c,
                   {data_out, data_valid, busy, overrun, bit_cnt}, dbg_state, model_vec(), m_busy);
        bad++;
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_overrun();
    test_coincident_ack();
    test_abort_restart();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
